// File: rtl/bifrost_pkg.sv
// bifrost_pkg: sequencer state encoding, default parameters and counter sizing helper
package bifrost_pkg;
    typedef enum logic [2:0] {
        IDLE,
        BOOT,
        HANDOVER,
        RST_HOLD,
        RUN,
        FAULT
    } state_t;
    localparam int DEF_DIV_LOG2     = 2;
    localparam int DEF_RESET_CYCLES = 8;
    localparam int DEF_BOOT_TIMEOUT = 1048576;
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction
endpackage

// File: rtl/clkdiv.sv
// clkdiv: free-running divide-by-2^(DIV_LOG2+1) clock; rise/fall strobes lead the clk_out edge by one
// cycle, so anything registered on a strobe changes together with clk_out.
module clkdiv
    import bifrost_pkg::*;
#(
    parameter int DIV_LOG2 = DEF_DIV_LOG2
) (
    input  logic clock,
    input  logic clear,
    output logic clk_out,
    output logic rise,
    output logic fall
);
    localparam int W = DIV_LOG2 + 1;
    localparam logic [W-1:0] HALF_M1 = W'((1 << DIV_LOG2) - 1);
    logic [W-1:0] div;
    always_ff @(posedge clock) begin
        div <= clear ? '0 : div + 1'b1;
    end
    assign clk_out = div[W-1];
    assign rise    = !clear && (div == HALF_M1);
    assign fall    = !clear && (&div);
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: boot loader handover, 6502 clock/reset sequencing and boot timeout.
// Define SINGLE_STEP_EN to build the RDY single-step logic; otherwise cpu_rdy is tied high.
module cpu_sequencer
    import bifrost_pkg::*;
#(
    parameter int DIV_LOG2     = DEF_DIV_LOG2,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int BOOT_TIMEOUT = DEF_BOOT_TIMEOUT
) (
    input  logic clock,
    input  logic reset,
    output logic boot_start,
    input  logic boot_done,
    output logic busen,
    output logic cpu_clk,
    output logic cpu_reset_n,
    output logic cpu_rdy,
    input  logic step_mode,
    input  logic step_req,
    output logic fault
);
    localparam int TW = cnt_width(BOOT_TIMEOUT);
    localparam int RW = cnt_width(RESET_CYCLES);
    localparam logic [TW-1:0] T_MAX  = TW'(BOOT_TIMEOUT);
    localparam logic [RW-1:0] R_MAX  = RW'(RESET_CYCLES);
    localparam logic [RW-1:0] R_LAST = RW'(RESET_CYCLES - 1);

    state_t state, state_nxt;
    logic [TW-1:0] tcnt;
    logic [RW-1:0] rcnt;
    logic ho;
    logic running, div_clear, clk_rise, clk_fall;
    logic boot_first, timeout;

    assign running    = (state == RST_HOLD) || (state == RUN);
    assign div_clear  = reset || !running;
    assign boot_first = (tcnt == TW'(1));
    assign timeout    = (tcnt == T_MAX);

    clkdiv #(.DIV_LOG2(DIV_LOG2)) u_clkdiv (
        .clock  (clock),
        .clear  (div_clear),
        .clk_out(cpu_clk),
        .rise   (clk_rise),
        .fall   (clk_fall)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     state_nxt = BOOT;
            BOOT:     state_nxt = (!boot_first && boot_done) ? HANDOVER : timeout ? FAULT : BOOT;
            HANDOVER: state_nxt = ho ? RST_HOLD : HANDOVER;
            RST_HOLD: state_nxt = (clk_fall && rcnt == R_LAST) ? RUN : RST_HOLD;
            default:  state_nxt = state;
        endcase
    end

    // tcnt holds the 1-based index of the current BOOT cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            tcnt  <= '0;
            rcnt  <= '0;
            ho    <= 1'b0;
        end else begin
            state <= state_nxt;
            tcnt  <= (state == IDLE) ? TW'(1) : (state == BOOT && !timeout) ? tcnt + 1'b1 : tcnt;
            ho    <= (state == HANDOVER) && !ho;
            rcnt  <= !running ? '0 : (clk_fall && rcnt != R_MAX) ? rcnt + 1'b1 : rcnt;
        end
    end

    assign boot_start  = (state == BOOT) && boot_first;
    assign busen       = running;
    assign cpu_reset_n = (state == RUN);
    assign fault       = (state == FAULT);

`ifdef SINGLE_STEP_EN
    logic rdy, pend;
    // requests arriving while a step is pending or executing merge into it
    always_ff @(posedge clock) begin
        if (reset || state != RUN) begin
            rdy  <= 1'b1;
            pend <= 1'b0;
        end else if (clk_rise) begin
            rdy  <= !step_mode || pend;
            pend <= step_mode && !pend && step_req;
        end else begin
            pend <= pend || (step_req && !rdy);
        end
    end
    assign cpu_rdy = rdy;
`else
    logic unused_step;
    assign unused_step = ^{step_mode, step_req, clk_rise};
    assign cpu_rdy = 1'b1;
`endif
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: scoreboard bench; dut uses defaults, dut_t uses BOOT_TIMEOUT=16, both share stimulus.
module tb_cpu_sequencer;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic boot_done = 1'b0;
    logic step_mode = 1'b0;
    logic step_req = 1'b0;
    logic bs0, bus0, clk0, rn0, rdy0, flt0;
    logic bs1, bus1, clk1, rn1, rdy1, flt1;
    logic [5:0] o [2];

    cpu_sequencer dut (
        .clock(clock), .reset(reset), .boot_start(bs0), .boot_done(boot_done), .busen(bus0),
        .cpu_clk(clk0), .cpu_reset_n(rn0), .cpu_rdy(rdy0), .step_mode(step_mode),
        .step_req(step_req), .fault(flt0)
    );
    cpu_sequencer #(.BOOT_TIMEOUT(16)) dut_t (
        .clock(clock), .reset(reset), .boot_start(bs1), .boot_done(boot_done), .busen(bus1),
        .cpu_clk(clk1), .cpu_reset_n(rn1), .cpu_rdy(rdy1), .step_mode(step_mode),
        .step_req(step_req), .fault(flt1)
    );

    assign o[0] = {bs0, bus0, clk0, rn0, rdy0, flt0};
    assign o[1] = {bs1, bus1, clk1, rn1, rdy1, flt1};

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];
    logic [31:0] got[$];
    int compared = 0;
    int mismatched = 0;
    string nm [8] = '{"n_bs", "t_bs", "t_bus", "t_clk", "t_rn", "t_flt", "n_flt", "n_nrdy"};
    logic [31:0] ov [2][8];

    task automatic do_reset(input int done_at);
        @(negedge clock);
        reset = 1'b1;
        step_mode = 1'b0;
        step_req = 1'b0;
        boot_done = (done_at == 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // cycle c = 1 is the first cycle after reset release; boot_done is high from cycle done_at on
    task automatic observe(input int done_at, input int limit);
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 8; i++) ov[d][i] = 0;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clock);
            for (int d = 0; d < 2; d++) begin
                if (o[d][5]) begin
                    ov[d][0]++;
                    if (ov[d][1] == 0) ov[d][1] = c;
                end
                if (o[d][4] && ov[d][2] == 0) ov[d][2] = c;
                if (o[d][3] && ov[d][3] == 0) ov[d][3] = c;
                if (o[d][2] && ov[d][4] == 0) ov[d][4] = c;
                if (o[d][0]) begin
                    if (ov[d][5] == 0) ov[d][5] = c;
                    ov[d][6]++;
                end
                if (o[d][1] !== 1'b1) ov[d][7]++;
            end
            boot_done = (done_at >= 0) && (c >= done_at);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            sb.push_back('{$sformatf("reset%0d.outs", d), 32'b000010});
            got.push_back(32'(o[d]));
        end
        while (sb.size() > 0) begin
            exp_t e;
            logic [31:0] g;
            e = sb.pop_front();
            g = got.pop_front();
            compared++;
            if (g !== e.exp) begin
                mismatched++;
                $display("FAIL %s: got %0d, expected %0d", e.name, g, e.exp);
            end
        end
    endtask

    task automatic run_boot_case(input string tag, input int done_at, input int limit,
                                 input logic [31:0] e0 [8], input logic [31:0] e1 [8]);
        do_reset(done_at);
        for (int i = 0; i < 8; i++) sb.push_back('{$sformatf("%s0.%s", tag, nm[i]), e0[i]});
        for (int i = 0; i < 8; i++) sb.push_back('{$sformatf("%s1.%s", tag, nm[i]), e1[i]});
        observe(done_at, limit);
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 8; i++) got.push_back(ov[d][i]);
        while (sb.size() > 0) begin
            exp_t e;
            logic [31:0] g;
            e = sb.pop_front();
            g = got.pop_front();
            compared++;
            if (g !== e.exp) begin
                mismatched++;
                $display("FAIL %s: got %0d, expected %0d", e.name, g, e.exp);
            end
        end
    endtask

    // boot_done held from cycle 0: BOOT = cycles 1-2, HANDOVER 3-4, RST_HOLD from 5
    task automatic test_boot_fast;
        logic [31:0] e [8] = '{1, 1, 5, 9, 69, 0, 0, 0};
        run_boot_case("fast", 0, 80, e, e);
    endtask

    // boot_done at BOOT cycle 100; the 16-cycle timeout instance faults at cycle 17 and stays there
    task automatic test_boot_late;
        logic [31:0] e0 [8] = '{1, 1, 103, 107, 167, 0, 0, 0};
        logic [31:0] e1 [8] = '{1, 1, 0, 0, 0, 17, 164, 0};
        run_boot_case("late", 100, 180, e0, e1);
    endtask

    // boot_done arrives in the cycle the timeout is reached: done wins
    task automatic test_timeout_tie;
        logic [31:0] e [8] = '{1, 1, 19, 23, 83, 0, 0, 0};
        run_boot_case("tie", 16, 100, e, e);
    endtask

    task automatic test_reset_mid;
        do_reset(0);
        repeat (26) @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            sb.push_back('{$sformatf("mid%0d.pre_busen_clk", d), 32'b11});
            got.push_back(32'({o[d][4], o[d][3]}));
        end
        reset = 1'b1;
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            sb.push_back('{$sformatf("mid%0d.reset_outs", d), 32'b000010});
            got.push_back(32'(o[d]));
        end
        reset = 1'b0;
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            sb.push_back('{$sformatf("mid%0d.new_boot_start", d), 32'd1});
            got.push_back(32'(o[d][5]));
        end
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            sb.push_back('{$sformatf("mid%0d.boot_start_drop", d), 32'd0});
            got.push_back(32'(o[d][5]));
        end
        while (sb.size() > 0) begin
            exp_t e;
            logic [31:0] g;
            e = sb.pop_front();
            g = got.pop_front();
            compared++;
            if (g !== e.exp) begin
                mismatched++;
                $display("FAIL %s: got %0d, expected %0d", e.name, g, e.exp);
            end
        end
    endtask

    task automatic test_step;
        int n_rdy = 0;
        int aligned = -1;
        logic prev_clk;
        do_reset(0);
        repeat (80) @(negedge clock);
        step_mode = 1'b1;
        repeat (20) @(negedge clock);
`ifdef SINGLE_STEP_EN
        sb.push_back('{"step.rdy_cycles", 32'd8});
        sb.push_back('{"step.rdy_on_rise", 32'd1});
`else
        sb.push_back('{"step.rdy_cycles", 32'd40});
`endif
        sb.push_back('{"step.free_run_rdy", 32'd1});
        prev_clk = clk0;
        for (int k = 0; k < 40; k++) begin
            step_req = (k == 0 || k == 2 || k == 4);
            @(negedge clock);
            step_req = 1'b0;
            if (rdy0 === 1'b1) begin
                n_rdy++;
                if (aligned < 0) aligned = (clk0 === 1'b1 && prev_clk === 1'b0) ? 1 : 0;
            end
            prev_clk = clk0;
        end
        got.push_back(n_rdy);
`ifdef SINGLE_STEP_EN
        got.push_back(aligned);
`endif
        step_mode = 1'b0;
        repeat (10) @(negedge clock);
        got.push_back(32'(rdy0));
        while (sb.size() > 0) begin
            exp_t e;
            logic [31:0] g;
            e = sb.pop_front();
            g = got.pop_front();
            compared++;
            if (g !== e.exp) begin
                mismatched++;
                $display("FAIL %s: got %0d, expected %0d", e.name, g, e.exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_boot_fast();
        test_boot_late();
        test_timeout_tie();
        test_reset_mid();
        test_step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
